// File: rtl/rns_pkg.sv
// Shared definitions for the RNS channel datapath: default moduli set,
// residue MAC state encoding and the conditional-subtract modular add.
package rns_pkg;

  localparam int unsigned MODULI [3] = '{7, 5, 8};

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    ACCUM,
    OUT
  } state_t;

  // Both operands must already be below m, so one subtract is enough.
  function automatic int unsigned mod_add(input int unsigned a,
                                          input int unsigned b,
                                          input int unsigned m);
    int unsigned s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

endpackage

// File: rtl/rns_mod_step.sv
// One restoring-division step: subtract (MODULUS << k) from r when it fits.
module rns_mod_step #(
  parameter int MODULUS = 7,
  parameter int W       = 6,
  parameter int KW      = 2
) (
  input  logic [W-1:0]  r,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  r_next
);

  // One extra bit: the largest shifted modulus can equal 2^W.
  logic [W:0] sub_val;

  assign sub_val = (W+1)'(MODULUS) << k;
  assign r_next  = ({1'b0, r} >= sub_val) ? (r - sub_val[W-1:0]) : r;

endmodule

// File: rtl/rns_residue_mac.sv
// Residue MAC for one RNS channel: reduces raw products mod MODULUS with a
// sequential restoring subtract, then accumulates them until the last product.
module rns_residue_mac
  import rns_pkg::*;
#(
  parameter int MODULUS = 7,
  parameter int PROD_W  = 6,
  parameter int RES_W   = 3,
  parameter int STEPS   = PROD_W - $clog2(MODULUS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_residue,
  output logic [3:0]        acc_count,
  output logic              busy
);

  localparam int KW = $clog2(STEPS);

  generate
    if (MODULUS < 2 || MODULUS > 8) begin : g_bad_modulus
      $error("rns_residue_mac: MODULUS must be in 2..8");
    end
    if ((1 << RES_W) < MODULUS) begin : g_bad_res_w
      $error("rns_residue_mac: RES_W too narrow for MODULUS");
    end
  endgenerate

  state_t            state;
  logic [PROD_W-1:0] r;
  logic [PROD_W-1:0] r_step;
  logic [KW-1:0]     k;
  logic              last;
  logic [RES_W-1:0]  acc;
  logic [RES_W-1:0]  acc_sum;

  rns_mod_step #(
    .MODULUS (MODULUS),
    .W       (PROD_W),
    .KW      (KW)
  ) u_step (
    .r      (r),
    .k      (k),
    .r_next (r_step)
  );

  // After REDUCE, r < MODULUS so it fits RES_W bits and the add is exact.
  assign acc_sum = RES_W'(mod_add(32'(acc), 32'(r), MODULUS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      r           <= '0;
      k           <= '0;
      last        <= 1'b0;
      acc         <= '0;
      acc_count   <= '0;
      out_residue <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r        <= in_prod;
            last     <= in_last;
            k        <= KW'(STEPS - 1);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= REDUCE;
          end
        end
        REDUCE: begin
          r <= r_step;
          k <= k - 1'b1;
          if (k == '0) state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc_sum;
          if (acc_count != 4'd15) acc_count <= acc_count + 4'd1;
          if (last) begin
            out_residue <= acc_sum;
            out_valid   <= 1'b1;
            state       <= OUT;
          end else begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            acc       <= '0;
            acc_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_residue_mac.sv
// Directed bench for rns_residue_mac: a MODULUS=7 instance and a MODULUS=5
// instance, hand-computed residues, latency, backpressure and reset abort.
module tb_rns_residue_mac;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last, out_ready;
  logic [5:0] in_prod;
  logic       in_ready, out_valid, busy;
  logic [2:0] out_residue;
  logic [3:0] acc_count;

  logic       in_valid5, in_last5, out_ready5;
  logic [5:0] in_prod5;
  logic       in_ready5, out_valid5, busy5;
  logic [2:0] out_residue5;
  logic [3:0] acc_count5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rns_residue_mac #(.MODULUS(7)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_residue(out_residue),
    .acc_count(acc_count), .busy(busy)
  );

  rns_residue_mac #(.MODULUS(5)) dut5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid5), .in_ready(in_ready5), .in_prod(in_prod5), .in_last(in_last5),
    .out_valid(out_valid5), .out_ready(out_ready5), .out_residue(out_residue5),
    .acc_count(acc_count5), .busy(busy5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? in_ready5 : in_ready;
  endfunction
  function automatic logic ov(input bit sel);
    return sel ? out_valid5 : out_valid;
  endfunction
  function automatic logic [2:0] res(input bit sel);
    return sel ? out_residue5 : out_residue;
  endfunction
  function automatic logic [3:0] cnt(input bit sel);
    return sel ? acc_count5 : acc_count;
  endfunction

  // Called at a falling edge; returns at the falling edge right after the accept edge.
  task automatic send(input bit sel, input logic [5:0] p, input logic l, input string tag);
    int n = 0;
    while (!rdy(sel) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, 32'(rdy(sel)), 32'd1);
    if (sel) begin
      in_valid5 = 1'b1; in_prod5 = p; in_last5 = l;
    end else begin
      in_valid = 1'b1; in_prod = p; in_last = l;
    end
    @(negedge clk);
    in_valid5 = 1'b0;
    in_valid  = 1'b0;
  endtask

  // Five more edges after the accept: REDUCE x4 then ACCUM.
  task automatic wait_done(input bit sel, input logic exp_out, input string tag);
    int j = 0;
    while (!(rdy(sel) || ov(sel)) && j < 50) begin
      @(negedge clk);
      j++;
    end
    check({tag, " latency"}, 32'(j), 32'd5);
    check({tag, " out_valid"}, 32'(ov(sel)), 32'(exp_out));
  endtask

  task automatic handshake(input bit sel, input string tag);
    if (sel) out_ready5 = 1'b1; else out_ready = 1'b1;
    @(negedge clk);
    out_ready5 = 1'b0;
    out_ready  = 1'b0;
    check({tag, " hs out_valid"}, 32'(ov(sel)), 32'd0);
    check({tag, " hs in_ready"}, 32'(rdy(sel)), 32'd1);
    check({tag, " hs acc_count"}, 32'(cnt(sel)), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_prod = '0; out_ready = 1'b0;
    in_valid5 = 1'b0; in_last5 = 1'b0; in_prod5 = '0; out_ready5 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_residue", 32'(out_residue), 32'd0);
    check("rst acc_count", 32'(acc_count), 32'd0);
    check("rst busy", 32'(busy), 32'd0);

    // One-term accumulation
    send(0, 6'd6, 1'b1, "p6");
    wait_done(0, 1'b1, "p6");
    check("p6 residue", 32'(res(0)), 32'd6);
    check("p6 count", 32'(acc_count), 32'd1);
    check("p6 busy", 32'(busy), 32'd1);
    handshake(0, "p6");

    // 49,36,25 -> 0+1+4 = 5
    send(0, 6'd49, 1'b0, "p49");
    wait_done(0, 1'b0, "p49");
    check("p49 count", 32'(acc_count), 32'd1);
    check("p49 busy", 32'(busy), 32'd0);
    send(0, 6'd36, 1'b0, "p36");
    wait_done(0, 1'b0, "p36");
    check("p36 count", 32'(acc_count), 32'd2);
    send(0, 6'd25, 1'b1, "p25");
    wait_done(0, 1'b1, "p25");
    check("sum3 residue", 32'(res(0)), 32'd5);
    check("sum3 count", 32'(acc_count), 32'd3);
    handshake(0, "sum3");

    // Out-of-range products and accumulator clear
    send(0, 6'd63, 1'b1, "p63");
    wait_done(0, 1'b1, "p63");
    check("p63 residue", 32'(res(0)), 32'd0);
    handshake(0, "p63");
    send(0, 6'd62, 1'b1, "p62");
    wait_done(0, 1'b1, "p62");
    check("p62 residue", 32'(res(0)), 32'd6);
    handshake(0, "p62");

    // out_ready while idle must not clear a partial accumulation
    send(0, 6'd3, 1'b0, "p3");
    wait_done(0, 1'b0, "p3");
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    check("idle rdy out_valid", 32'(out_valid), 32'd0);
    check("idle rdy count", 32'(acc_count), 32'd1);
    send(0, 6'd2, 1'b1, "p2");
    wait_done(0, 1'b1, "p2");
    check("3+2 residue", 32'(res(0)), 32'd5);
    check("3+2 count", 32'(acc_count), 32'd2);
    handshake(0, "3+2");

    // Backpressure with in_valid held high
    send(0, 6'd10, 1'b1, "p10");
    wait_done(0, 1'b1, "p10");
    in_valid = 1'b1; in_prod = 6'd5; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp residue", 32'(out_residue), 32'd3);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    handshake(0, "bp");
    send(0, 6'd4, 1'b1, "p4");
    wait_done(0, 1'b1, "p4");
    check("after bp residue", 32'(res(0)), 32'd4);
    check("after bp count", 32'(acc_count), 32'd1);
    handshake(0, "p4");

    // Reset during REDUCE discards the partial accumulation
    send(0, 6'd4, 1'b0, "pre");
    wait_done(0, 1'b0, "pre");
    send(0, 6'd20, 1'b1, "p20");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst out_valid", 32'(out_valid), 32'd0);
    check("mid rst count", 32'(acc_count), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(0, 6'd3, 1'b1, "post");
    wait_done(0, 1'b1, "post");
    check("post rst residue", 32'(res(0)), 32'd3);
    check("post rst count", 32'(acc_count), 32'd1);
    handshake(0, "post");

    // MODULUS=5: 42,13 -> 2+3 = 0; 63 -> 3
    send(1, 6'd42, 1'b0, "m5 p42");
    wait_done(1, 1'b0, "m5 p42");
    send(1, 6'd13, 1'b1, "m5 p13");
    wait_done(1, 1'b1, "m5 p13");
    check("m5 residue", 32'(res(1)), 32'd0);
    check("m5 count", 32'(acc_count5), 32'd2);
    handshake(1, "m5");
    send(1, 6'd63, 1'b1, "m5 p63");
    wait_done(1, 1'b1, "m5 p63");
    check("m5 p63 residue", 32'(res(1)), 32'd3);
    handshake(1, "m5 p63");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
